arbiter_4_rr: RTL and testbench
===============================

Name: arbiter_4_rr

Overview:
Four-requester round-robin arbiter with grant hold and a fairness timeout. It shares a single resource (bus, encoder output slot, shared datapath) between four requesters. Its default priority order is 3 > 2 > 1 > 0, and it rotates after each grant. Outputs are a registered one-hot grant and the encoded grant index with a valid flag.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while others wait; 0 = unlimited hold (no timeout)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req  input  4  request lines; req[i]=1 means requester i wants the resource
gnt  output  4  one-hot grant, registered; all zeros when nothing granted
gnt_id  output  2  binary index of granted requester; 2'b00 when gnt_valid=0
gnt_valid  output  1  1 while any grant is active; equals |gnt

Behaviour:
- Reset: on a rising edge with rst_n=0, the block goes to IDLE. Reset values: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, hold_cnt=0, last=2'b00.
- Search order: winner = first asserted req scanning last-1, last-2, last-3, last (mod 4, descending).
  - After reset, last=0, so the order is 3,2,1,0, which matches the fixed 4:2 priority encoder.
  - The most recent grantee is always lowest priority.
- States: IDLE, GRANT. State and outputs are registered; there is no combinational path from req to outputs.
- IDLE:
  - If |req=0: stay in IDLE, outputs stay at zero.
  - If |req=1: select winner w. Next cycle: state=GRANT, gnt=1<<w, gnt_id=w, gnt_valid=1, hold_cnt=1.
  - Latency is 1 cycle from req sampled to gnt visible.
- GRANT (current grantee c = gnt_id), evaluated each edge:
  - Release: req[c]=0.
  - Timeout: MAX_HOLD!=0 and hold_cnt==MAX_HOLD and some req[j]=1 with j!=c.
  - Release or timeout: last<=c; the winner is searched among requests excluding c.
    - Winner w found: gnt switches directly to w on the next cycle, hold_cnt=1. No idle gap; gnt_valid stays 1.
    - No winner: go to IDLE; gnt, gnt_id and gnt_valid clear on the next cycle.
  - Otherwise the grant is held. hold_cnt increments, saturating at MAX_HOLD.
  - Lone requester reaching MAX_HOLD with no other req: grant continues uninterrupted and hold_cnt reloads to 1.
- Simultaneous release and timeout: treated as release (same outcome).
- Changes on non-granted req lines during GRANT only affect the next arbitration; the current grant is never pre-empted except by timeout.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1 bit. With MAX_HOLD=0 the counter is held at 0 and timeout never fires.
- A grant lasts exactly MAX_HOLD cycles under continuous contention.
- Reset asserted mid-grant: outputs clear on that edge regardless of req. The first grant after rst_n rises uses order 3,2,1,0.

Optional Feature:
ARB_FIXED_PRIORITY_EN
- Defined: rotation disabled. last is never updated (stays 0), so every arbitration uses 3 > 2 > 1 > 0. Hold, release and timeout rules are unchanged; on timeout the highest other requester wins.
- Undefined: round-robin rotation as described in Behaviour.

Test Plan:
- Reset mid-grant: grant active on req=4'b0100, assert rst_n=0 for 1 edge → gnt=0000, gnt_valid=0 that cycle. Release reset with req=4'b1001 → gnt=1000 one cycle later.
- Single request/release: req=4'b0100 → gnt=0100, gnt_id=2, gnt_valid=1 one cycle later. Drop req[2] → gnt=0000, gnt_valid=0 one cycle later.
- Back-to-back handover: req=4'b1010 → gnt=1000. Drop req[3] → gnt=0010 next cycle with gnt_valid continuously 1. Drop req[1] → idle.
- Timeout rotation, MAX_HOLD=4: req=4'b1111 held 20 cycles → gnt sequence 1000,0100,0010,0001,1000, each exactly 4 cycles, no gaps.
- Lone holder, MAX_HOLD=4: req=4'b0001 held 12 cycles → gnt=0001 for all 12 cycles, gnt_valid never drops.
- ARB_FIXED_PRIORITY_EN defined: grant 3, release it, then req=4'b1111 → gnt=1000 again. Without the macro, the same stimulus gives gnt=0100.

Source files
------------

// File: rtl/arbiter_4_rr_if.sv
// Request/grant bundle shared by the four requesters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface arbiter_4_rr_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/arbiter_4_rr.sv
// Four-requester round-robin arbiter with grant hold and a MAX_HOLD fairness timeout.
// Define ARB_FIXED_PRIORITY_EN to freeze the priority order at 3 > 2 > 1 > 0.
module arbiter_4_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    arbiter_4_rr_if.slave bus
);

    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] CNT_ONE    = (MAX_HOLD == 0) ? '0 : HCW'(1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      id_q, id_d;
    logic            valid_q, valid_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [1:0]      last_q, last_d;

    logic [2:0]      pick;
    logic [3:0]      others;
    logic [1:0]      search_base;
    logic            release_hit;
    logic            timeout_hit;

    // Returns {found, index}; scans base-1, base-2, base-3, base so base is always lowest priority.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            idx = base - 2'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'b00;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        id_d        = id_q;
        valid_d     = valid_q;
        hold_d      = hold_q;
        last_d      = last_q;
        pick        = 3'b000;
        others      = 4'b0000;
        search_base = last_q;
        release_hit = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                pick = rr_pick(bus.req, last_q);
                if (pick[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick[1:0];
                    id_d    = pick[1:0];
                    valid_d = 1'b1;
                    hold_d  = CNT_ONE;
                end else begin
                    gnt_d   = 4'b0000;
                    id_d    = 2'b00;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end
            end

            GRANT: begin
                others      = bus.req & ~gnt_q;
                release_hit = !bus.req[id_q];
                timeout_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LIMIT) && (|others);

                if (release_hit || timeout_hit) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    search_base = last_q;
`else
                    last_d      = id_q;
                    search_base = id_q;
`endif
                    pick = rr_pick(others, search_base);
                    if (pick[2]) begin
                        gnt_d   = 4'b0001 << pick[1:0];
                        id_d    = pick[1:0];
                        valid_d = 1'b1;
                        hold_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        id_d    = 2'b00;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (MAX_HOLD == 0) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LIMIT) begin
                    // Lone holder at the limit: nobody to hand over to, so restart the window.
                    hold_d = CNT_ONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                id_d    = 2'b00;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;

    gnt_onehot_a: assert property (@(posedge clk) $onehot0(gnt_q));
    gnt_valid_a:  assert property (@(posedge clk) valid_q == (|gnt_q));
    gnt_id_a:     assert property (@(posedge clk) gnt_q == (valid_q ? (4'b0001 << id_q) : 4'b0000));

endmodule

// File: tb/tb_arbiter_4_rr.sv
// Self-checking bench for arbiter_4_rr: directed scenarios plus randomized requests,
// all compared against a behavioural model of the round-robin/hold/timeout rules.
module tb_arbiter_4_rr;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;
    int   nVectors;
    int   nMiscompares;

    // Behavioural model: owner is the granted requester or -1 when idle.
    int   mOwner;
    int   mCnt;
    int   mLast;

    arbiter_4_rr_if bus();

    arbiter_4_rr #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pickWinner(input int mask, input int lastIdx);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (lastIdx - k + 8) % 4;
            if (((mask >> idx) & 1) == 1) return idx;
        end
        return -1;
    endfunction

    task automatic modelStep(input logic [3:0] r, input logic rn);
        int  others;
        int  w;
        bit  releaseHit;
        bit  timeoutHit;
        if (!rn) begin
            mOwner = -1;
            mCnt   = 0;
            mLast  = 0;
        end else if (mOwner < 0) begin
            w = pickWinner(int'(r), mLast);
            if (w >= 0) begin
                mOwner = w;
                mCnt   = 1;
            end
        end else begin
            others     = int'(r) & ~(1 << mOwner);
            releaseHit = (((int'(r) >> mOwner) & 1) == 0);
            timeoutHit = (MAX_HOLD > 0) && (mCnt == MAX_HOLD) && (others != 0);
            if (releaseHit || timeoutHit) begin
`ifndef ARB_FIXED_PRIORITY_EN
                mLast = mOwner;
`endif
                w = pickWinner(others, mLast);
                mOwner = w;
                mCnt   = (w >= 0) ? 1 : 0;
            end else begin
                mCnt = (mCnt >= MAX_HOLD) ? 1 : mCnt + 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare off-edge.
    task automatic applyStimulus(input logic [3:0] r, input logic rn);
        logic [3:0] expGnt;
        bus.req = r;
        rst_n   = rn;
        @(posedge clk);
        modelStep(r, rn);
        #1;
        expGnt = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
        checkOutput("gnt",       32'(bus.gnt),       32'(expGnt));
        checkOutput("gnt_id",    32'(bus.gnt_id),    (mOwner < 0) ? 32'd0 : 32'(mOwner));
        checkOutput("gnt_valid", 32'(bus.gnt_valid), (mOwner < 0) ? 32'd0 : 32'd1);
    endtask

    logic [3:0] rotSeq [5];
    logic [3:0] rndReq;
    logic       rndRst;

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        mOwner       = -1;
        mCnt         = 0;
        mLast        = 0;
        bus.req      = 4'b0000;
        rst_n        = 1'b0;
        rotSeq[0] = 4'b1000;
        rotSeq[1] = 4'b0100;
        rotSeq[2] = 4'b0010;
        rotSeq[3] = 4'b0001;
        rotSeq[4] = 4'b1000;

        $display("[TB] reset and reset mid-grant");
        applyStimulus(4'b0000, 1'b0);
        checkOutput("reset_gnt", 32'(bus.gnt), 32'h0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_gnt", 32'(bus.gnt), 32'b0100);
        applyStimulus(4'b0100, 1'b0);
        checkOutput("midreset_gnt", 32'(bus.gnt), 32'h0);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("after_reset_gnt", 32'(bus.gnt), 32'b1000);

        $display("[TB] single request and release");
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_id", 32'(bus.gnt_id), 32'd2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("release_valid", 32'(bus.gnt_valid), 32'd0);

        $display("[TB] back-to-back handover");
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b1010, 1'b1);
        checkOutput("b2b_first", 32'(bus.gnt), 32'b1000);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("b2b_second", 32'(bus.gnt), 32'b0010);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("b2b_idle", 32'(bus.gnt), 32'h0);

        $display("[TB] timeout rotation under full contention");
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1111, 1'b1);
`ifndef ARB_FIXED_PRIORITY_EN
            checkOutput("rotation", 32'(bus.gnt), 32'(rotSeq[i / 4]));
`endif
        end

        $display("[TB] lone holder past the limit");
        applyStimulus(4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b0001, 1'b1);
            checkOutput("lone_gnt", 32'(bus.gnt), 32'b0001);
        end

        $display("[TB] priority after a released grant");
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b1111, 1'b1);
`ifdef ARB_FIXED_PRIORITY_EN
        checkOutput("prio_after_release", 32'(bus.gnt), 32'b1000);
`else
        checkOutput("prio_after_release", 32'(bus.gnt), 32'b0100);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rndReq = 4'($urandom_range(0, 15));
            rndRst = ($urandom_range(0, 49) != 0);
            applyStimulus(rndReq, rndRst);
            if ($urandom_range(0, 3) != 0) begin
                for (int j = 0; j < $urandom_range(1, 6); j++) applyStimulus(rndReq, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
